// File: rtl/change_dispenser.sv
// change_dispenser: greedy 20/10/5 coin payout engine with per-denomination
// stock counters and a valid/ready handshake toward the coin hopper.
//
//   state | meaning
//   IDLE  | waiting for a change request; refills applied here only
//   SEL   | pick largest coin that fits remaining and is in stock
//   PAY   | offer selected coin to hopper until it is taken
//   FIN   | one-cycle done pulse, short flag valid
module change_dispenser #(
  parameter int AMT_W  = 8,
  parameter int CNT_W  = 4,
  parameter int INIT20 = 4,
  parameter int INIT10 = 4,
  parameter int INIT5  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             req_err,
  output logic             coin_valid,
  output logic [4:0]       coin_value,
  input  logic             coin_ready,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic [CNT_W-1:0] stock20,
  output logic [CNT_W-1:0] stock10,
  output logic [CNT_W-1:0] stock5
);

  typedef enum logic [1:0] {IDLE, SEL, PAY, FIN} state_t;

  state_t           state, state_nxt;
  logic [4:0]       coin_sel;
  logic [4:0]       pick;
  logic             short_q;
  logic             req_err_q;
  logic [AMT_W-1:0] rem_q;
  logic [CNT_W-1:0] s20, s10, s5;
  logic             amt_ok;
  logic             accept;
  logic             fit20, fit10, fit5;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign amt_ok = (req_amount % AMT_W'(5)) == '0;
  assign accept = req_valid && (state == IDLE);
  assign fit20  = (rem_q >= AMT_W'(20)) && (s20 != '0);
  assign fit10  = (rem_q >= AMT_W'(10)) && (s10 != '0);
  assign fit5   = (rem_q >= AMT_W'(5))  && (s5  != '0);

  assign req_err   = req_err_q;
  assign short     = short_q;
  assign remaining = rem_q;
  assign stock20   = s20;
  assign stock10   = s10;
  assign stock5    = s5;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, handshake outputs and greedy coin pick
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    coin_valid = 1'b0;
    coin_value = 5'd0;
    done       = 1'b0;
    pick       = 5'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && amt_ok) state_nxt = SEL;
      end
      SEL: begin
        if (fit20)      pick = 5'd20;
        else if (fit10) pick = 5'd10;
        else if (fit5)  pick = 5'd5;
        state_nxt = (pick != 5'd0) ? PAY : FIN;
      end
      PAY: begin
        coin_valid = 1'b1;
        coin_value = coin_sel;
        if (coin_ready) state_nxt = SEL;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: amount owed, selected coin, flags and stock counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      coin_sel  <= 5'd0;
      short_q   <= 1'b0;
      req_err_q <= 1'b0;
      s20       <= CNT_W'(INIT20);
      s10       <= CNT_W'(INIT10);
      s5        <= CNT_W'(INIT5);
    end else begin
      req_err_q <= accept && !amt_ok;
      case (state)
        IDLE: begin
          if (refill_valid) begin
            case (refill_sel)
              2'd0:    s5  <= sat_add(s5,  refill_cnt);
              2'd1:    s10 <= sat_add(s10, refill_cnt);
              2'd2:    s20 <= sat_add(s20, refill_cnt);
              default: ;
            endcase
          end
          if (accept && amt_ok) begin
            rem_q   <= req_amount;
            short_q <= 1'b0;
          end
        end
        SEL: begin
          if (pick != 5'd0) coin_sel <= pick;
          else              short_q  <= (rem_q != '0);
        end
        PAY: begin
          if (coin_ready) begin
            rem_q <= rem_q - AMT_W'(coin_sel);
            case (coin_sel)
              5'd20:   s20 <= s20 - CNT_W'(1);
              5'd10:   s10 <= s10 - CNT_W'(1);
              5'd5:    s5  <= s5  - CNT_W'(1);
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
